// File: rtl/regfile_alu_sequencer.sv
// regfile_alu_sequencer
//   Multi-cycle sequencer that turns one register-to-register instruction
//   into a read / execute / write-back sequence against an external 8x8
//   register file and add/sub ULA.
//
//   Ports
//     iCLK, iRST_N            clock (rising edge), async active-low reset
//     i_valid / o_ready       instruction handshake (accept only in IDLE)
//     i_op,i_rd,i_rs1,i_rs2,i_imm   instruction fields
//                             (op: 00 LDI, 01 ADD, 10 SUB, 11 MOV)
//     o_done                  one-cycle retire pulse
//     o_result,o_ovf,o_zero   status of the last retired instruction
//     o_we3,o_wa3,o_wd3       register file write port
//     o_ra1,o_ra2,i_rd1,i_rd2 register file read ports (combinational data)
//     o_alu_sel,o_alu_a,o_alu_b,i_alu_s,i_alu_ovf   ULA interface
module regfile_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_op,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic [DATA_W-1:0] i_imm,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf,
    output logic              o_zero,
    output logic              o_we3,
    output logic [ADDR_W-1:0] o_wa3,
    output logic [DATA_W-1:0] o_wd3,
    output logic [ADDR_W-1:0] o_ra1,
    output logic [ADDR_W-1:0] o_ra2,
    input  logic [DATA_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_rd2,
    output logic              o_alu_sel,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic [DATA_W-1:0] i_alu_s,
    input  logic              i_alu_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] result_q;
    logic              ovf_tmp;
    logic [ADDR_W-1:0] wa3_q;
    logic [ADDR_W-1:0] ra1_q, ra2_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic              alu_sel_q;

    // State register. Async reset drops straight to IDLE, which also kills
    // o_we3 immediately since it is decoded from state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_we3     = 1'b0;
        o_done    = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = (i_op == OP_LDI) ? S_WRITE : S_READ;
            end
            S_READ:  state_nxt = (op_q == OP_MOV) ? S_WRITE : S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: begin
                o_we3     = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath. Every interface register is only loaded on the edge that
    // enters the state that uses it, so each one holds outside that state.
    // result_q doubles as the write data: it only changes on WRITE entry.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            op_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            ovf_tmp   <= 1'b0;
            wa3_q     <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= 1'b0;
            o_result  <= '0;
            o_ovf     <= 1'b0;
            o_zero    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        op_q <= i_op;
                        rd_q <= i_rd;
                        if (i_op == OP_LDI) begin
                            result_q <= i_imm;
                            wa3_q    <= i_rd;
                        end else begin
                            ra1_q <= i_rs1;
                            ra2_q <= i_rs2;
                        end
                    end
                end
                S_READ: begin
                    if (op_q == OP_MOV) begin
                        result_q <= i_rd1;
                        wa3_q    <= rd_q;
                    end else begin
                        alu_a_q   <= i_rd1;
                        alu_b_q   <= i_rd2;
                        alu_sel_q <= (op_q == OP_SUB);
                    end
                end
                S_EXEC: begin
                    result_q <= i_alu_s;
                    ovf_tmp  <= i_alu_ovf;
                    wa3_q    <= rd_q;
                end
                S_WRITE: begin
                    // Status becomes visible together with o_done.
                    o_result <= result_q;
                    o_zero   <= (result_q == '0);
                    if (op_q == OP_ADD || op_q == OP_SUB) o_ovf <= ovf_tmp;
                end
                default: ;
            endcase
        end
    end

    assign o_wa3     = wa3_q;
    assign o_wd3     = result_q;
    assign o_ra1     = ra1_q;
    assign o_ra2     = ra2_q;
    assign o_alu_a   = alu_a_q;
    assign o_alu_b   = alu_b_q;
    assign o_alu_sel = alu_sel_q;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: a stand-in register file and ULA close the
// loop around the sequencer; a per-instruction reference model predicts the
// written value, overflow flag and latency.
module tb_regfile_alu_sequencer;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [2:0] i_rd, i_rs1, i_rs2;
    logic [7:0] i_imm;
    logic       o_done;
    logic [7:0] o_result;
    logic       o_ovf, o_zero;
    logic       o_we3;
    logic [2:0] o_wa3;
    logic [7:0] o_wd3;
    logic [2:0] o_ra1, o_ra2;
    logic [7:0] i_rd1, i_rd2;
    logic       o_alu_sel;
    logic [7:0] o_alu_a, o_alu_b;
    logic [7:0] i_alu_s;
    logic       i_alu_ovf;

    always #5 iCLK = ~iCLK;

    regfile_alu_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_done(o_done), .o_result(o_result), .o_ovf(o_ovf), .o_zero(o_zero),
        .o_we3(o_we3), .o_wa3(o_wa3), .o_wd3(o_wd3),
        .o_ra1(o_ra1), .o_ra2(o_ra2), .i_rd1(i_rd1), .i_rd2(i_rd2),
        .o_alu_sel(o_alu_sel), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_s(i_alu_s), .i_alu_ovf(i_alu_ovf)
    );

    // Environment: register file and ULA stand-ins.
    logic [7:0] rf [8];
    logic       rf_clr;
    always @(posedge iCLK) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (o_we3) begin
            rf[o_wa3] <= o_wd3;
        end
    end
    assign i_rd1     = rf[o_ra1];
    assign i_rd2     = rf[o_ra2];
    assign i_alu_s   = o_alu_sel ? (o_alu_a - o_alu_b) : (o_alu_a + o_alu_b);
    assign i_alu_ovf = o_alu_sel
        ? ((o_alu_a[7] != o_alu_b[7]) && (i_alu_s[7] != o_alu_a[7]))
        : ((o_alu_a[7] == o_alu_b[7]) && (i_alu_s[7] != o_alu_a[7]));

    // Reference model state.
    logic [7:0] model_rf [8];
    logic       model_ovf;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Instruction semantics from signed-integer arithmetic.
    function automatic void model_predict(input logic [1:0] op, input logic [2:0] rs1,
                                          input logic [2:0] rs2, input logic [7:0] imm,
                                          output logic [7:0] ev, output logic eo);
        int a, b, r;
        a  = int'($signed(model_rf[rs1]));
        b  = int'($signed(model_rf[rs2]));
        ev = imm;
        eo = model_ovf;
        case (op)
            OP_LDI: ev = imm;
            OP_MOV: ev = model_rf[rs1];
            OP_ADD: begin r = a + b; ev = 8'(r); eo = (r > 127) || (r < -128); end
            default: begin r = a - b; ev = 8'(r); eo = (r > 127) || (r < -128); end
        endcase
    endfunction

    // Issue one instruction from a negedge with the DUT idle; returns at the
    // negedge of the first cycle after retirement.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm,
                         input logic [7:0] ev, input logic eo);
        int lat, wcyc, dcyc, nwe, ndone;
        logic [7:0] a, b;
        a   = model_rf[rs1];
        b   = model_rf[rs2];
        lat = (op == OP_LDI) ? 2 : (op == OP_MOV) ? 3 : 4;
        chk("ready_idle", o_ready, 1);
        i_valid = 1'b1; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        @(posedge iCLK);
        @(negedge iCLK);
        i_valid = 1'b0;
        i_op = 2'($urandom); i_rd = 3'($urandom); i_rs1 = 3'($urandom);
        i_rs2 = 3'($urandom); i_imm = 8'($urandom);
        wcyc = 0; dcyc = 0; nwe = 0; ndone = 0;
        for (int k = 1; k <= lat; k++) begin
            chk("ready_busy", o_ready, 0);
            if (k == 1 && op != OP_LDI) begin
                chk("ra1", o_ra1, rs1);
                chk("ra2", o_ra2, rs2);
            end
            if (k == 2 && (op == OP_ADD || op == OP_SUB)) begin
                chk("alu_sel", o_alu_sel, (op == OP_SUB));
                chk("alu_a", o_alu_a, a);
                chk("alu_b", o_alu_b, b);
            end
            if (o_we3) begin
                nwe++; wcyc = k;
                chk("wa3", o_wa3, rd);
                chk("wd3", o_wd3, ev);
            end
            if (o_done) begin
                ndone++; dcyc = k;
                chk("result", o_result, ev);
                chk("zero", o_zero, (ev == 8'h00));
                chk("ovf", o_ovf, eo);
            end
            @(negedge iCLK);
        end
        chk("we_pulses", nwe, 1);
        chk("done_pulses", ndone, 1);
        chk("write_cycle", wcyc, lat - 1);
        chk("done_cycle", dcyc, lat);
        model_rf[rd] = ev;
        model_ovf    = eo;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm;
        logic [7:0] ev;
        logic       eo;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic [7:0] imm,
                                input logic [7:0] ev, input logic eo);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.ev = ev; v.eo = eo;
        return v;
    endfunction

    typedef struct {
        logic [2:0] rd;
        logic [7:0] val;
    } wr_t;

    initial begin
        vec_t tbl [12];
        wr_t  expq [$];
        wr_t  w;
        logic [1:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm, ev;
        logic       eo;
        int   n_acc, n_wr, n_done;

        tbl[0]  = mk(OP_LDI, 3'd3, 3'd0, 3'd0, 8'h2A, 8'h2A, 1'b0);
        tbl[1]  = mk(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h70, 8'h70, 1'b0);
        tbl[2]  = mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0);
        tbl[3]  = mk(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00, 8'h90, 1'b1);
        tbl[4]  = mk(OP_MOV, 3'd6, 3'd4, 3'd0, 8'h00, 8'h90, 1'b1);
        tbl[5]  = mk(OP_LDI, 3'd7, 3'd0, 3'd0, 8'h01, 8'h01, 1'b1);
        tbl[6]  = mk(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b1);
        tbl[7]  = mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h05, 8'h05, 1'b1);
        tbl[8]  = mk(OP_SUB, 3'd5, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0);
        tbl[9]  = mk(OP_ADD, 3'd0, 3'd7, 3'd7, 8'h00, 8'h02, 1'b0);
        tbl[10] = mk(OP_ADD, 3'd7, 3'd7, 3'd7, 8'h00, 8'h02, 1'b0);
        tbl[11] = mk(OP_SUB, 3'd3, 3'd6, 3'd3, 8'h00, 8'h66, 1'b1);

        for (int i = 0; i < 8; i++) model_rf[i] = 8'h00;
        model_ovf = 1'b0;
        iRST_N = 1'b0; rf_clr = 1'b1; i_valid = 1'b0;
        i_op = 2'b00; i_rd = 3'd0; i_rs1 = 3'd0; i_rs2 = 3'd0; i_imm = 8'h00;

        // Reset state
        @(negedge iCLK);
        @(negedge iCLK);
        chk("rst_ready", o_ready, 1);
        chk("rst_we3", o_we3, 0);
        chk("rst_done", o_done, 0);
        chk("rst_result", o_result, 0);
        chk("rst_zero", o_zero, 1);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_alu_sel", o_alu_sel, 0);
        chk("rst_wa3", o_wa3, 0);
        chk("rst_ra1", o_ra1, 0);
        iRST_N = 1'b1; rf_clr = 1'b0;
        @(negedge iCLK);

        // Directed table
        for (int i = 0; i < 12; i++)
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].ev, tbl[i].eo);
        chk("rf_r4", rf[4], 8'h90);
        chk("rf_r6", rf[6], 8'h90);
        chk("rf_r5", rf[5], 8'h00);

        // Reset asserted while an ADD is in WRITE: write must be aborted.
        i_valid = 1'b1; i_op = OP_ADD; i_rd = 3'd2; i_rs1 = 3'd0; i_rs2 = 3'd0;
        @(posedge iCLK);
        @(negedge iCLK);
        i_valid = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        chk("abort_we3_before", o_we3, 1);
        iRST_N = 1'b0;
        #1;
        chk("abort_we3_async", o_we3, 0);
        chk("abort_ready_async", o_ready, 1);
        @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        chk("abort_rf_r2", rf[2], model_rf[2]);
        chk("abort_ovf", o_ovf, 0);
        chk("abort_zero", o_zero, 1);
        model_ovf = 1'b0;
        issue(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hC3, 8'hC3, 1'b0);

        // i_valid held high with fields changing every cycle.
        n_acc = 0; n_wr = 0; n_done = 0;
        for (int c = 0; c < 70; c++) begin
            if (o_we3) begin
                n_wr++;
                if (expq.size() == 0) begin
                    chk("held_spurious_write", 1, 0);
                end else begin
                    w = expq.pop_front();
                    chk("held_wa3", o_wa3, w.rd);
                    chk("held_wd3", o_wd3, w.val);
                end
            end
            if (o_done) n_done++;
            if (c < 60) begin
                op = 2'($urandom); rd = 3'($urandom); rs1 = 3'($urandom);
                rs2 = 3'($urandom); imm = 8'($urandom);
                i_valid = 1'b1; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
                if (o_ready) begin
                    model_predict(op, rs1, rs2, imm, ev, eo);
                    model_rf[rd] = ev;
                    model_ovf    = eo;
                    w.rd = rd; w.val = ev;
                    expq.push_back(w);
                    n_acc++;
                end
            end else begin
                i_valid = 1'b0;
            end
            @(negedge iCLK);
        end
        chk("held_all_written", n_wr, n_acc);
        chk("held_all_done", n_done, n_acc);
        chk("held_ovf", o_ovf, model_ovf);

        // Randomised instructions against the model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom); rd = 3'($urandom); rs1 = 3'($urandom);
            rs2 = 3'($urandom); imm = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            model_predict(op, rs1, rs2, imm, ev, eo);
            issue(op, rd, rs1, rs2, imm, ev, eo);
        end
        for (int i = 0; i < 8; i++) chk("final_rf", rf[i], model_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
